pc_stack: RTL and testbench



---
 rtl/pc_stack_if.sv | 43 ++++
 rtl/pc_stack.sv | 138 +++++++++++++
 tb/tb_pc_stack.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_if
// Description : Fetch-side bundle between decode/branch logic and the
//               program counter with return-address stack.
//               master : decode/branch logic (drives operation and operands)
//               slave  : pc_stack (returns PC, link, depth and sticky flags)
// Signals     : I_enable   advance/update strobe (0 = stall)
//               I_op       operation code (INC/JUMP/BRANCH/CALL/RET/HOLD)
//               I_target   absolute target for JUMP and CALL
//               I_offset   two's-complement offset for BRANCH
//               O_out      current PC
//               O_link     top-of-stack return address (0 when empty)
//               O_depth    number of valid stack entries
//               O_overflow sticky CALL-while-full flag
//               O_underflow sticky RET-while-empty flag
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DW    = 4
);
    logic             I_enable;
    logic [2:0]       I_op;
    logic [WIDTH-1:0] I_target;
    logic [WIDTH-1:0] I_offset;
    logic [WIDTH-1:0] O_out;
    logic [WIDTH-1:0] O_link;
    logic [DW-1:0]    O_depth;
    logic             O_overflow;
    logic             O_underflow;

    modport master (
        output I_enable, I_op, I_target, I_offset,
        input  O_out, O_link, O_depth, O_overflow, O_underflow
    );

    modport slave (
        input  I_enable, I_op, I_target, I_offset,
        output O_out, O_link, O_depth, O_overflow, O_underflow
    );
endinterface
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack
// Description : Parametrised program counter with increment, absolute jump,
//               PC-relative branch and a hardware return-address stack for
//               CALL/RET. All outputs are registered; every update happens on
//               the rising edge of I_clk when bus.I_enable is high.
// Ports       : I_clk    clock, rising edge
//               I_reset  synchronous, active-high reset (priority over all)
//               bus      pc_stack_if.slave (operation in, PC/stack state out)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack #(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               DEPTH     = 8,
    parameter int               DW        = $clog2(DEPTH + 1)
) (
    input logic        I_clk,
    input logic        I_reset,
    pc_stack_if.slave  bus
);

    localparam int               c_PW       = $clog2(DEPTH);
    localparam logic [2:0]       c_OP_INC    = 3'd0;
    localparam logic [2:0]       c_OP_JUMP   = 3'd1;
    localparam logic [2:0]       c_OP_BRANCH = 3'd2;
    localparam logic [2:0]       c_OP_CALL   = 3'd3;
    localparam logic [2:0]       c_OP_RET    = 3'd4;
    localparam logic [WIDTH-1:0] c_STEP      = WIDTH'(STEP);
    localparam logic [DW-1:0]    c_DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0]    c_ONE       = DW'(1);

    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [WIDTH-1:0] link_q,  link_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [WIDTH-1:0] w_seq_pc;
    logic             w_full;
    logic             w_empty;
    logic [c_PW-1:0]  w_push_idx;
    logic [c_PW-1:0]  w_top_idx;
    logic [c_PW-1:0]  w_below_idx;

    // Depth doubles as the stack pointer: entry depth-1 is the top.
    assign w_seq_pc    = pc_q + c_STEP;
    assign w_full      = (depth_q == c_DEPTH_MAX);
    assign w_empty     = (depth_q == '0);
    assign w_push_idx  = c_PW'(depth_q);
    assign w_top_idx   = c_PW'(depth_q - c_ONE);
    assign w_below_idx = c_PW'(depth_q - DW'(2));

    always_comb begin
        pc_d    = pc_q;
        link_d  = link_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stack_d = stack_q;

        if (bus.I_enable) begin
            case (bus.I_op)
                c_OP_INC: begin
                    pc_d = w_seq_pc;
                end
                c_OP_JUMP: begin
                    pc_d = bus.I_target;
                end
                c_OP_BRANCH: begin
                    // Relative to the current instruction, not the next one.
                    pc_d = pc_q + bus.I_offset;
                end
                c_OP_CALL: begin
                    // The jump is taken even when the push has to be dropped.
                    pc_d = bus.I_target;
                    if (w_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        stack_d[w_push_idx] = w_seq_pc;
                        depth_d             = depth_q + c_ONE;
                        link_d              = w_seq_pc;
                    end
                end
                c_OP_RET: begin
                    if (w_empty) begin
                        pc_d  = w_seq_pc;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stack_q[w_top_idx];
                        depth_d = depth_q - c_ONE;
                        // Link is registered, so pre-load the entry that
                        // becomes the new top (or 0 once the stack drains).
                        link_d  = (depth_q == c_ONE) ? '0 : stack_q[w_below_idx];
                    end
                end
                default: begin
                    // HOLD and reserved opcodes leave all state untouched.
                end
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            pc_q    <= RESET_VEC;
            link_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            link_q  <= link_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry contents need no reset: depth=0 marks them all invalid.
    always_ff @(posedge I_clk) begin
        if (!I_reset) begin
            stack_q <= stack_d;
        end
    end

    assign bus.O_out       = pc_q;
    assign bus.O_link      = link_q;
    assign bus.O_depth     = depth_q;
    assign bus.O_overflow  = ovf_q;
    assign bus.O_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack
// Description : Directed self-checking bench for pc_stack
//               (WIDTH=16, STEP=2, RESET_VEC=0x0100, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack;

    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_BRANCH = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;
    localparam logic [2:0] OP_HOLD   = 3'd5;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [15:0] links [8];

    pc_stack_if #(.WIDTH(16), .DW(4)) bus ();

    pc_stack #(
        .WIDTH     (16),
        .STEP      (2),
        .RESET_VEC (16'h0100),
        .DEPTH     (8)
    ) u_dut (
        .I_clk   (clk),
        .I_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one operation across one rising edge, return #1 after the edge.
    task automatic step(input logic en, input logic [2:0] op,
                        input logic [15:0] tgt, input logic [15:0] off);
        bus.I_enable = en;
        bus.I_op     = op;
        bus.I_target = tgt;
        bus.I_offset = off;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] pc,
                             input logic [15:0] link, input logic [3:0] depth,
                             input logic ovf, input logic unf);
        chk({tag, ".out"},   32'(bus.O_out),       32'(pc));
        chk({tag, ".link"},  32'(bus.O_link),      32'(link));
        chk({tag, ".depth"}, 32'(bus.O_depth),     32'(depth));
        chk({tag, ".ovf"},   32'(bus.O_overflow),  32'(ovf));
        chk({tag, ".unf"},   32'(bus.O_underflow), 32'(unf));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.I_enable = 1'b0;
        bus.I_op     = OP_HOLD;
        bus.I_target = '0;
        bus.I_offset = '0;

        // Reset state
        step(1'b0, OP_HOLD, 16'h0, 16'h0);
        step(1'b0, OP_HOLD, 16'h0, 16'h0);
        chk_state("reset", 16'h0100, 16'h0000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Sequential increments with a 3-cycle stall in the middle
        step(1'b1, OP_INC, 16'h0, 16'h0);
        chk("inc1", 32'(bus.O_out), 32'h0102);
        step(1'b1, OP_INC, 16'h0, 16'h0);
        chk("inc2", 32'(bus.O_out), 32'h0104);
        step(1'b0, OP_INC, 16'h0, 16'h0);
        chk("stall1", 32'(bus.O_out), 32'h0104);
        step(1'b0, OP_CALL, 16'h1234, 16'h0);
        chk("stall2", 32'(bus.O_out), 32'h0104);
        step(1'b0, OP_JUMP, 16'h5678, 16'h0);
        chk_state("stall3", 16'h0104, 16'h0000, 4'd0, 1'b0, 1'b0);
        step(1'b1, OP_INC, 16'h0, 16'h0);
        chk("inc3", 32'(bus.O_out), 32'h0106);
        step(1'b1, OP_INC, 16'h0, 16'h0);
        chk("inc4", 32'(bus.O_out), 32'h0108);

        // Branches, including a negative offset and a wrap past 0xFFFF
        step(1'b1, OP_JUMP, 16'h0010, 16'h0);
        chk("jump10", 32'(bus.O_out), 32'h0010);
        step(1'b1, OP_BRANCH, 16'h0, 16'hFFF0);
        chk("br_neg", 32'(bus.O_out), 32'h0000);
        step(1'b1, OP_JUMP, 16'hFFFE, 16'h0);
        chk("jumpFFFE", 32'(bus.O_out), 32'hFFFE);
        step(1'b1, OP_BRANCH, 16'h0, 16'h0004);
        chk_state("br_wrap", 16'h0002, 16'h0000, 4'd0, 1'b0, 1'b0);

        // Nested CALL / RET
        step(1'b1, OP_JUMP, 16'h0020, 16'h0);
        step(1'b1, OP_CALL, 16'h0400, 16'h0);
        chk_state("call1", 16'h0400, 16'h0022, 4'd1, 1'b0, 1'b0);
        step(1'b1, OP_CALL, 16'h0800, 16'h0);
        chk_state("call2", 16'h0800, 16'h0402, 4'd2, 1'b0, 1'b0);
        step(1'b1, OP_RET, 16'h0, 16'h0);
        chk_state("ret1", 16'h0402, 16'h0022, 4'd1, 1'b0, 1'b0);
        step(1'b1, OP_RET, 16'h0, 16'h0);
        chk_state("ret2", 16'h0022, 16'h0000, 4'd0, 1'b0, 1'b0);

        // Nine CALLs from PC 0x0022: targets 0x1000,0x1100,..,0x1800.
        // Pushed links: 0x0024, then previous target + 2.
        links[0] = 16'h0024;
        for (int i = 1; i < 8; i++) links[i] = 16'h1002 + 16'(16'h0100 * (i - 1));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, OP_CALL, 16'h1000 + 16'(16'h0100 * i), 16'h0);
            chk_state($sformatf("fill%0d", i), 16'h1000 + 16'(16'h0100 * i),
                      links[i], 4'(i + 1), 1'b0, 1'b0);
        end
        step(1'b1, OP_CALL, 16'h1800, 16'h0);
        chk_state("call_full", 16'h1800, 16'h1602, 4'd8, 1'b1, 1'b0);

        // Unwind: links come back in reverse order
        for (int k = 0; k < 8; k++) begin
            step(1'b1, OP_RET, 16'h0, 16'h0);
            chk_state($sformatf("unwind%0d", k), links[7 - k],
                      (k < 7) ? links[6 - k] : 16'h0000, 4'(7 - k), 1'b1, 1'b0);
        end

        // RET on an empty stack
        step(1'b1, OP_JUMP, 16'h0030, 16'h0);
        step(1'b1, OP_RET, 16'h0, 16'h0);
        chk_state("ret_empty", 16'h0032, 16'h0000, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, OP_INC, 16'h0, 16'h0);
        chk_state("unf_sticky", 16'h003C, 16'h0000, 4'd0, 1'b1, 1'b1);

        // Build depth 3 with flags still set, then reset during a CALL
        step(1'b1, OP_CALL, 16'h0200, 16'h0);
        step(1'b1, OP_CALL, 16'h0300, 16'h0);
        step(1'b1, OP_CALL, 16'h0400, 16'h0);
        chk_state("depth3", 16'h0400, 16'h0302, 4'd3, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, OP_CALL, 16'h0900, 16'h0);
        rst = 1'b0;
        chk_state("rst_call", 16'h0100, 16'h0000, 4'd0, 1'b0, 1'b0);

        // HOLD and reserved opcodes with enable high
        step(1'b1, OP_INC, 16'h0, 16'h0);
        step(1'b1, OP_CALL, 16'h0500, 16'h0);
        chk_state("pre_hold", 16'h0500, 16'h0104, 4'd1, 1'b0, 1'b0);
        step(1'b1, 3'd6, 16'hAAAA, 16'h5555);
        chk_state("op6", 16'h0500, 16'h0104, 4'd1, 1'b0, 1'b0);
        step(1'b1, 3'd7, 16'hBBBB, 16'h1111);
        chk_state("op7", 16'h0500, 16'h0104, 4'd1, 1'b0, 1'b0);
        step(1'b1, OP_HOLD, 16'hCCCC, 16'h2222);
        chk_state("hold", 16'h0500, 16'h0104, 4'd1, 1'b0, 1'b0);
        step(1'b0, OP_RET, 16'h0, 16'h0);
        chk_state("stall_ret", 16'h0500, 16'h0104, 4'd1, 1'b0, 1'b0);
        step(1'b1, OP_RET, 16'h0, 16'h0);
        chk_state("final_ret", 16'h0104, 16'h0000, 4'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
